// File: rtl/layer_compositor_if.sv
// SRAM-side bus of the layer compositor.
//   read_enable  : block read strobe; read_data is valid the following cycle
//   write_enable : block write strobe
//   address      : block address, 0 whenever neither strobe is active
//   read_data    : block read data from the SRAM
//   write_data   : block write data to the SRAM
// master = compositor side, slave = SRAM/arbiter side.
interface layer_compositor_if #(
  parameter int unsigned ADDR_SIZE_BITS = 24,
  parameter int unsigned DATA_BITS      = 1536
);
  logic                      read_enable;
  logic                      write_enable;
  logic [ADDR_SIZE_BITS-1:0] address;
  logic [DATA_BITS-1:0]      read_data;
  logic [DATA_BITS-1:0]      write_data;

  modport master (
    output read_enable,
    output write_enable,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  read_enable,
    input  write_enable,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/layer_compositor.sv
// Multi-mode two-layer compositor. Streams DATA_SIZE_WORDS-pixel blocks from two
// source layers, combines them PIX_PER_CYCLE pixels per clock and writes the
// result block to the destination region.
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   start               : job request, sampled only when idle
//   mode                : 0 alpha blend, 1 saturating add, 2 colour key, 3 copy
//   alpha_value         : layer 1 weight (clamped to 2**ALPHA_BITS)
//   key_color           : transparent layer 1 pixel for colour-key mode
//   src1_base/src2_base : layer start addresses
//   dst_base            : output start address
//   block_count         : number of blocks in the job
//   busy, done          : job in progress / one-cycle completion pulse
//   sram                : SRAM bus (master side)
module layer_compositor #(
  parameter int unsigned ADDR_SIZE_BITS  = 24,
  parameter int unsigned WORD_SIZE_BYTES = 3,
  parameter int unsigned DATA_SIZE_WORDS = 64,
  parameter int unsigned PIX_PER_CYCLE   = 4,
  parameter int unsigned ALPHA_BITS      = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [ALPHA_BITS:0]            alpha_value,
  input  logic [WORD_SIZE_BYTES*8-1:0]   key_color,
  input  logic [ADDR_SIZE_BITS-1:0]      src1_base,
  input  logic [ADDR_SIZE_BITS-1:0]      src2_base,
  input  logic [ADDR_SIZE_BITS-1:0]      dst_base,
  input  logic [15:0]                    block_count,
  output logic                           busy,
  output logic                           done,
  layer_compositor_if.master             sram
);

  localparam int unsigned PixBits    = WORD_SIZE_BYTES * 8;
  localparam int unsigned BlockBits  = PixBits * DATA_SIZE_WORDS;
  localparam int unsigned GroupBits  = PixBits * PIX_PER_CYCLE;
  localparam int unsigned PixIdxBits = $clog2(DATA_SIZE_WORDS);

  localparam logic [ALPHA_BITS:0]   AlphaMax  = {1'b1, {ALPHA_BITS{1'b0}}};
  localparam logic [PixIdxBits-1:0] LastGroup = PixIdxBits'(DATA_SIZE_WORDS - PIX_PER_CYCLE);
  localparam logic [PixIdxBits-1:0] PixStep   = PixIdxBits'(PIX_PER_CYCLE);

  localparam logic [1:0] ModeAlpha = 2'd0;
  localparam logic [1:0] ModeAdd   = 2'd1;
  localparam logic [1:0] ModeKey   = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StRead1, StWait1, StRead2, StWait2, StBlend, StWrite1, StWrite2, StUpdate, StDone
  } state_e;

  state_e                    state_q;
  logic [1:0]                mode_q;
  logic [ALPHA_BITS:0]       alpha_q;
  logic [PixBits-1:0]        key_q;
  logic [ADDR_SIZE_BITS-1:0] src1_q;
  logic [ADDR_SIZE_BITS-1:0] src2_q;
  logic [ADDR_SIZE_BITS-1:0] dst_q;
  logic [15:0]               count_q;
  logic [15:0]               blk_q;
  logic [PixIdxBits-1:0]     p_q;
  logic [BlockBits-1:0]      buf1_q;
  logic [BlockBits-1:0]      buf2_q;

  logic [15:0]               blk_next;
  logic [GroupBits-1:0]      group_out;

  assign blk_next = blk_q + 16'd1;

  function automatic logic [ADDR_SIZE_BITS-1:0] blk_addr(input logic [ADDR_SIZE_BITS-1:0] base,
                                                         input logic [15:0] b);
    // Wraps modulo 2**ADDR_SIZE_BITS by construction.
    return base + ADDR_SIZE_BITS'(b) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
  endfunction

  function automatic logic [PixBits-1:0] combine_pixel(input logic [1:0]          m,
                                                       input logic [ALPHA_BITS:0] a,
                                                       input logic [PixBits-1:0]  key,
                                                       input logic [PixBits-1:0]  c1,
                                                       input logic [PixBits-1:0]  c2);
    logic [PixBits-1:0]    res;
    logic [ALPHA_BITS:0]   inv;
    logic [ALPHA_BITS+8:0] wsum;
    logic [8:0]            ssum;
    res  = '0;
    inv  = AlphaMax - a;
    wsum = '0;
    ssum = '0;
    case (m)
      ModeAlpha: begin
        // 8+ALPHA_BITS+1 bits holds 255*ALPHA_MAX, so the weighted sum never overflows.
        for (int b = 0; b < int'(WORD_SIZE_BYTES); b++) begin
          wsum = ({{(ALPHA_BITS+1){1'b0}}, c1[b*8 +: 8]} * {8'd0, a}) +
                 ({{(ALPHA_BITS+1){1'b0}}, c2[b*8 +: 8]} * {8'd0, inv});
          res[b*8 +: 8] = 8'(wsum >> ALPHA_BITS);
        end
      end
      ModeAdd: begin
        for (int b = 0; b < int'(WORD_SIZE_BYTES); b++) begin
          ssum = {1'b0, c1[b*8 +: 8]} + {1'b0, c2[b*8 +: 8]};
          res[b*8 +: 8] = ssum[8] ? 8'hFF : ssum[7:0];
        end
      end
      ModeKey: res = (c1 == key) ? c2 : c1;
      default: res = c1;
    endcase
    return res;
  endfunction

  // Pixels p..p+PIX_PER_CYCLE-1 of the current block.
  always_comb begin
    group_out = '0;
    for (int i = 0; i < int'(PIX_PER_CYCLE); i++) begin
      group_out[i*PixBits +: PixBits] =
        combine_pixel(mode_q, alpha_q, key_q,
                      buf1_q[(int'(p_q) + i)*PixBits +: PixBits],
                      buf2_q[(int'(p_q) + i)*PixBits +: PixBits]);
    end
  end

  // Strobes, address, busy and done are registered: they are set on the edge that enters the
  // state in which they must be visible.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q           <= StIdle;
      mode_q            <= '0;
      alpha_q           <= '0;
      key_q             <= '0;
      src1_q            <= '0;
      src2_q            <= '0;
      dst_q             <= '0;
      count_q           <= '0;
      blk_q             <= '0;
      p_q               <= '0;
      buf1_q            <= '0;
      buf2_q            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      sram.read_enable  <= 1'b0;
      sram.write_enable <= 1'b0;
      sram.address      <= '0;
      sram.write_data   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            alpha_q <= (alpha_value > AlphaMax) ? AlphaMax : alpha_value;
            key_q   <= key_color;
            src1_q  <= src1_base;
            src2_q  <= src2_base;
            dst_q   <= dst_base;
            count_q <= block_count;
            blk_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRead1;
            // An empty job goes straight through READ1 to DONE without touching the SRAM.
            if (block_count != 16'd0) begin
              sram.read_enable <= 1'b1;
              sram.address     <= src1_base;
            end
          end
        end
        StRead1: begin
          sram.read_enable <= 1'b0;
          sram.address     <= '0;
          if (blk_q == count_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StWait1;
          end
        end
        StWait1: begin
          buf1_q           <= sram.read_data;
          sram.read_enable <= 1'b1;
          sram.address     <= blk_addr(src2_q, blk_q);
          state_q          <= StRead2;
        end
        StRead2: begin
          sram.read_enable <= 1'b0;
          sram.address     <= '0;
          state_q          <= StWait2;
        end
        StWait2: begin
          buf2_q  <= sram.read_data;
          p_q     <= '0;
          state_q <= StBlend;
        end
        StBlend: begin
          sram.write_data[int'(p_q)*PixBits +: GroupBits] <= group_out;
          p_q <= p_q + PixStep;
          if (p_q == LastGroup) begin
            sram.write_enable <= 1'b1;
            sram.address      <= blk_addr(dst_q, blk_q);
            state_q           <= StWrite1;
          end
        end
        StWrite1: state_q <= StWrite2;
        StWrite2: begin
          sram.write_enable <= 1'b0;
          sram.address      <= '0;
          state_q           <= StUpdate;
        end
        StUpdate: begin
          blk_q <= blk_next;
          // Finishing here rather than via READ1 saves a cycle per job.
          if (blk_next == count_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            sram.read_enable <= 1'b1;
            sram.address     <= blk_addr(src1_q, blk_next);
            state_q          <= StRead1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;
  localparam int unsigned AW = 24;
  localparam int unsigned NW = 64;
  localparam int unsigned PB = 24;
  localparam int unsigned BB = PB * NW;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [4:0]    alpha_value = '0;
  logic [PB-1:0] key_color = '0;
  logic [AW-1:0] src1_base = '0;
  logic [AW-1:0] src2_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [15:0]   block_count = '0;
  logic          busy;
  logic          done;

  layer_compositor_if #(.ADDR_SIZE_BITS(AW), .DATA_BITS(BB)) sram ();

  layer_compositor #(
    .ADDR_SIZE_BITS (AW),
    .WORD_SIZE_BYTES(3),
    .DATA_SIZE_WORDS(NW),
    .PIX_PER_CYCLE  (4),
    .ALPHA_BITS     (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .mode       (mode),
    .alpha_value(alpha_value),
    .key_color  (key_color),
    .src1_base  (src1_base),
    .src2_base  (src2_base),
    .dst_base   (dst_base),
    .block_count(block_count),
    .busy       (busy),
    .done       (done),
    .sram       (sram)
  );

  typedef struct packed {
    logic [1:0]    m;
    logic [4:0]    a;
    logic [PB-1:0] key;
    logic [PB-1:0] l1e;
    logic [PB-1:0] l1o;
    logic [PB-1:0] l2;
    logic [PB-1:0] ee;
    logic [PB-1:0] eo;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
  } wr_t;

  logic [BB-1:0] mem [int unsigned];
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_seen = 0;
  int we_seen = 0;
  int re_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (sram.read_enable) begin
      if (mem.exists(32'(sram.address))) sram.read_data <= mem[32'(sram.address)];
      else sram.read_data <= '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_block(input string name, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    int first;
    first = -1;
    n_vec++;
    for (int i = NW - 1; i >= 0; i--) begin
      if (got[i*PB +: PB] !== exp[i*PB +: PB]) first = i;
    end
    if (first >= 0) begin
      n_err++;
      $display("FAIL %s: pixel %0d got %06h expected %06h", name, first,
               got[first*PB +: PB], exp[first*PB +: PB]);
    end
  endtask

  function automatic logic [BB-1:0] fill(input logic [PB-1:0] e, input logic [PB-1:0] o);
    logic [BB-1:0] r;
    for (int i = 0; i < int'(NW); i++) r[i*PB +: PB] = (i % 2 == 0) ? e : o;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    wr_t           w;
    logic [AW-1:0] ea;
    if (n_rst) begin
      if (sram.read_enable && sram.write_enable) begin
        n_vec++;
        n_err++;
        $display("FAIL strobe_overlap: got both strobes high, required never together");
      end
      if (!sram.read_enable && !sram.write_enable && sram.address != '0) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_address: got %0h expected 0", sram.address);
      end
      if (done) done_seen++;
      if (sram.read_enable) begin
        re_seen++;
        if (rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: got read at %0h expected none", sram.address);
        end else begin
          ea = rd_q.pop_front();
          chk("read_address", 64'(sram.address), 64'(ea));
        end
      end
      if (sram.write_enable) begin
        we_seen++;
        if (wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got write at %0h expected none", sram.address);
        end else begin
          w = wr_q.pop_front();
          chk("write_address", 64'(sram.address), 64'(w.addr));
          chk_block("write_data", sram.write_data, w.data);
        end
      end
    end
  end

  task automatic push_write(input logic [AW-1:0] a, input logic [BB-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    // One entry per write strobe cycle; data must hold across both.
    wr_q.push_back(w);
    wr_q.push_back(w);
  endtask

  task automatic run_job(input logic [1:0] m, input logic [4:0] a, input logic [PB-1:0] key,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic [15:0] cnt,
                         input int exp_cyc, input int restart_at, input string name);
    int got;
    got = -1;
    @(posedge clk);
    #1;
    mode = m; alpha_value = a; key_color = key;
    src1_base = s1; src2_base = s2; dst_base = d; block_count = cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) chk({name, "_busy_first"}, 64'(busy), 64'd1);
      if (k == restart_at) begin
        start = 1'b1; block_count = 16'd1; dst_base = 24'h007000; mode = 2'd3;
      end else if (k == restart_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        got = k;
        break;
      end
    end
    chk({name, "_done_cycle"}, 64'(got), 64'(exp_cyc));
    chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_writes_left"}, 64'(wr_q.size()), 64'd0);
    chk({name, "_reads_left"}, 64'(rd_q.size()), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[8];
    logic [AW-1:0] s1, s2, d;
    logic [BB-1:0] blk;
    int            w0, r0, d0;

    vecs[0] = '{m:2'd0, a:5'd8,  key:24'h0, l1e:24'hC8C8C8, l1o:24'hC8C8C8, l2:24'h646464,
                ee:24'h969696, eo:24'h969696};
    vecs[1] = '{m:2'd0, a:5'd0,  key:24'h0, l1e:24'hC8C8C8, l1o:24'hC8C8C8, l2:24'h646464,
                ee:24'h646464, eo:24'h646464};
    vecs[2] = '{m:2'd0, a:5'd16, key:24'h0, l1e:24'hC8C8C8, l1o:24'hC8C8C8, l2:24'h646464,
                ee:24'hC8C8C8, eo:24'hC8C8C8};
    vecs[3] = '{m:2'd0, a:5'd20, key:24'h0, l1e:24'hC8C8C8, l1o:24'hC8C8C8, l2:24'h646464,
                ee:24'hC8C8C8, eo:24'hC8C8C8};
    vecs[4] = '{m:2'd1, a:5'd0,  key:24'h0, l1e:24'h8014C8, l1o:24'h8014C8, l2:24'h7F1E64,
                ee:24'hFF32FF, eo:24'hFF32FF};
    vecs[5] = '{m:2'd2, a:5'd0,  key:24'h00FF00, l1e:24'h00FF00, l1o:24'h112233, l2:24'hABCDEF,
                ee:24'hABCDEF, eo:24'h112233};
    vecs[6] = '{m:2'd3, a:5'd5,  key:24'h0, l1e:24'h123456, l1o:24'h654321, l2:24'hABCDEF,
                ee:24'h123456, eo:24'h654321};
    vecs[7] = '{m:2'd0, a:5'd3,  key:24'h0, l1e:24'hFF0010, l1o:24'hFF0010, l2:24'h00FF20,
                ee:24'h2FCF1D, eo:24'h2FCF1D};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_read_enable", 64'(sram.read_enable), 64'd0);
    chk("rst_write_enable", 64'(sram.write_enable), 64'd0);
    chk("rst_address", 64'(sram.address), 64'd0);
    chk_block("rst_write_data", sram.write_data, '0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Single-block jobs, one per table entry.
    for (int i = 0; i < 8; i++) begin
      s1 = 24'(24'h001000 * (i + 1));
      s2 = s1 + 24'h100000;
      d  = s1 + 24'h200000;
      mem.delete();
      mem[32'(s1)] = fill(vecs[i].l1e, vecs[i].l1o);
      mem[32'(s2)] = fill(vecs[i].l2, vecs[i].l2);
      rd_q.push_back(s1);
      rd_q.push_back(s2);
      push_write(d, fill(vecs[i].ee, vecs[i].eo));
      w0 = we_seen;
      run_job(vecs[i].m, vecs[i].a, vecs[i].key, s1, s2, d, 16'd1, 24, -1,
              $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_write_cycles", i), 64'(we_seen - w0), 64'd2);
    end

    // Three blocks, distinct pixel data per block, start pulsed mid-job.
    mem.delete();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < int'(NW); i++) blk[i*PB +: PB] = {8'(b + 1), 8'(i), 8'(i) ^ 8'hA5};
      mem[32'(b * 64)] = blk;
      mem[32'(65536 + b * 64)] = fill(24'hFFFFFF, 24'hFFFFFF);
      rd_q.push_back(24'(b * 64));
      rd_q.push_back(24'(65536 + b * 64));
      push_write(24'(143360 + b * 64), blk);
    end
    w0 = we_seen;
    run_job(2'd3, 5'd0, 24'h0, 24'd0, 24'd65536, 24'd143360, 16'd3, 70, 10, "multi");
    chk("multi_write_cycles", 64'(we_seen - w0), 64'd6);

    // Reset during BLEND of block 0 of a two-block job.
    mem.delete();
    mem[32'h400] = fill(24'h102030, 24'h405060);
    mem[32'h800] = fill(24'h0A0B0C, 24'h0D0E0F);
    rd_q.push_back(24'h000400);
    rd_q.push_back(24'h000800);
    @(posedge clk);
    #1;
    mode = 2'd0; alpha_value = 5'd8; src1_base = 24'h000400; src2_base = 24'h000800;
    dst_base = 24'h000C00; block_count = 16'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    d0 = done_seen;
    w0 = we_seen;
    n_rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_read_enable", 64'(sram.read_enable), 64'd0);
    chk("abort_write_enable", 64'(sram.write_enable), 64'd0);
    chk("abort_address", 64'(sram.address), 64'd0);
    chk_block("abort_write_data", sram.write_data, '0);
    chk("abort_reads_done", 64'(rd_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    chk("abort_no_write", 64'(we_seen - w0), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // Empty job after reset: done at cycle 2, no SRAM traffic.
    r0 = re_seen;
    w0 = we_seen;
    run_job(2'd0, 5'd8, 24'h0, 24'h000400, 24'h000800, 24'h000C00, 16'd0, 2, -1, "empty");
    chk("empty_no_read", 64'(re_seen - r0), 64'd0);
    chk("empty_no_write", 64'(we_seen - w0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised multi-mode compositor and the next generation of the two-layer alpha blender. It streams blocks of DATA_SIZE_WORDS pixels from two SRAM source layers at programmable base addresses, combines them and writes the result to a programmable destination region through the shared single-port SRAM interface. Supported combine modes are weighted alpha blend, saturating add, colour-key overlay and copy. Processing is PIX_PER_CYCLE pixels per clock. It sits between the GPU command sequencer (start/done) and the SRAM arbiter.

Parameters:
ADDR_SIZE_BITS, 24, SRAM address width
WORD_SIZE_BYTES, 3, bytes per pixel (R,G,B; byte 0 = lowest bits)
DATA_SIZE_WORDS, 64, pixels per SRAM block transfer
PIX_PER_CYCLE, 4, pixels combined per BLEND cycle; must divide DATA_SIZE_WORDS
ALPHA_BITS, 4, alpha fraction bits; ALPHA_MAX = 2**ALPHA_BITS

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
mode  in  2  0=ALPHA, 1=ADD_SAT, 2=COLOR_KEY, 3=COPY
alpha_value  in  ALPHA_BITS+1  layer1 weight, 0..ALPHA_MAX
key_color  in  WORD_SIZE_BYTES*8  transparent pixel value for COLOR_KEY
src1_base  in  ADDR_SIZE_BITS  layer 1 start address
src2_base  in  ADDR_SIZE_BITS  layer 2 start address
dst_base  in  ADDR_SIZE_BITS  output start address
block_count  in  16  number of blocks to process
busy  out  1  high from the first cycle after start is accepted until DONE, inclusive
done  out  1  one-cycle completion pulse
read_enable  out  1  SRAM read strobe
write_enable  out  1  SRAM write strobe
address  out  ADDR_SIZE_BITS  SRAM address
read_data  in  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  SRAM block read data
write_data  out  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  registered block write data

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; all outputs 0; write_data, internal buffers, counters and latched configuration cleared. Reset asserted mid-operation aborts immediately. No done pulse is issued. The partially built block is never written.
- Start acceptance: start in IDLE latches mode, alpha_value (clamped to ALPHA_MAX if larger), key_color, the three bases and block_count, then moves to READ1. Config inputs are ignored after this. start in any other state is ignored.
- FSM: IDLE -> READ1 -> WAIT1 -> READ2 -> WAIT2 -> BLEND (DATA_SIZE_WORDS/PIX_PER_CYCLE cycles) -> WRITE1 -> WRITE2 -> UPDATE -> READ1 ... -> DONE -> IDLE.
- READ1: if blk == block_count go to DONE. Otherwise address = src1_base + blk*DATA_SIZE_WORDS and read_enable = 1.
- WAIT1: capture read_data into buffer1. read_data is valid the cycle after the strobe.
- READ2 / WAIT2: same as READ1 / WAIT1, with src2_base into buffer2. WAIT2 also clears the pixel index p.
- BLEND: each cycle computes pixels p..p+PIX_PER_CYCLE-1 into write_data, then p += PIX_PER_CYCLE. Leaves after the last group.
- WRITE1 and WRITE2: write_enable = 1, address = dst_base + blk*DATA_SIZE_WORDS. write_data is stable in both cycles.
- UPDATE: blk += 1.
- DONE: done = 1 for one cycle, then IDLE.
- Cycles per block: 7 + DATA_SIZE_WORDS/PIX_PER_CYCLE, which is 23 at defaults. With start high at cycle 0, done is high at cycle 1 + 23*N. block_count = 0 gives done at cycle 2.
- Address arithmetic wraps modulo 2**ADDR_SIZE_BITS. read_enable and write_enable are never high together. address = 0 whenever no strobe is active.
- Arithmetic is per byte channel; c1 is from layer 1 and c2 from layer 2.
  - ALPHA: out = (c1*a + c2*(ALPHA_MAX - a)) >> ALPHA_BITS, computed at 8+ALPHA_BITS+1 bits, so no overflow. a = ALPHA_MAX gives exactly c1; a = 0 gives exactly c2.
  - ADD_SAT: out = min(c1 + c2, 255).
  - COLOR_KEY: compares the whole pixel. If the layer1 pixel equals key_color, output the layer2 pixel; otherwise output the layer1 pixel.
  - COPY: out = c1. Layer 2 is still read, which keeps timing identical across modes.

Test Plan:
- ALPHA, a=8, block_count=1, all layer1 bytes 200, all layer2 bytes 100 -> every output byte 150. Exactly 2 write_enable cycles at dst_base. done at cycle 24.
- ALPHA, a=0, then a=16, then a=20 -> output equals layer2 (100), then layer1 (200), then layer1 (200, clamped).
- ADD_SAT, c1=200, c2=100 in byte 0 and c1=20, c2=30 in byte 1 -> outputs 255 and 50.
- COLOR_KEY, key=0x00FF00, even pixels of layer1 = 0x00FF00, odd pixels = 0x112233, layer2 = 0xABCDEF -> even output pixels 0xABCDEF, odd 0x112233.
- block_count=3 with src1=0, src2=65536, dst=143360 -> write addresses 143360, 143424, 143488. done at cycle 70. start pulsed while busy is ignored.
- Reset deasserted-to-asserted during BLEND of block 0 -> all outputs 0 immediately, no write strobe, no done. A fresh start after reset release completes normally; block_count=0 -> done at cycle 2 with no SRAM access.
